// File: rtl/bus2st_arb.sv
// bus2st_arb: round-robin packet arbiter sharing the bus2st wide-bus input
// between up to four turbo-packet producers. A grant is held for one whole
// packet; a stall watchdog releases the bus if the owner stops sending.
module bus2st_arb #(
  parameter int BUS                   = 534,
  parameter int NUM_REQ               = 4,
  parameter int NUM_BUS_PER_TURBO_PKT = 25,
  parameter int TIMEOUT               = 1023
) (
  input  logic                   clk_400,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [NUM_REQ*BUS-1:0] in_data,
  input  logic [NUM_REQ-1:0]     in_en,
  output logic [NUM_REQ-1:0]     in_ready,
  output logic [NUM_REQ-1:0]     grant,
  output logic [BUS-1:0]         bus_data,
  output logic                   bus_en,
  input  logic                   bus_ready,
  output logic [1:0]             owner,
  output logic                   pkt_done,
  output logic                   err_timeout
);

  localparam int WCNT_W = ($clog2(NUM_BUS_PER_TURBO_PKT + 1) > 5) ?
                          $clog2(NUM_BUS_PER_TURBO_PKT + 1) : 5;
  localparam int SCNT_W = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;

  typedef enum logic {IDLE, BURST} state_t;

  state_t              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_d;
  logic [1:0]          owner_d;
  logic [1:0]          last_owner_q, last_owner_d;
  logic [WCNT_W-1:0]   word_cnt_q, word_cnt_d;
  logic [SCNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic                pkt_done_d, err_timeout_d;
  logic                accept, last_word, stall_limit;
  logic [1:0]          pick;
  logic                pick_valid;

  // Datapath: the granted producer drives the bus; everything is gated by the
  // one-hot grant, so an idle arbiter presents zeros and no handshakes.
  always_comb begin
    bus_data = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (grant[j]) bus_data = in_data[j*BUS +: BUS];
    end
    bus_en   = |(grant & in_en);
    in_ready = grant & {NUM_REQ{bus_ready}};
  end

  assign accept      = bus_en & bus_ready;
  assign last_word   = (word_cnt_q == WCNT_W'(NUM_BUS_PER_TURBO_PKT - 1));
  assign stall_limit = (stall_cnt_q == SCNT_W'(TIMEOUT - 1));

  // Round-robin pick: first requester found scanning upward from last_owner+1.
  always_comb begin
    pick       = last_owner_q;
    pick_valid = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!pick_valid && req[j] && (j == (int'(last_owner_q) + i) % NUM_REQ)) begin
          pick       = 2'(j);
          pick_valid = 1'b1;
        end
      end
    end
  end

  // Next-state logic: arbitrate in IDLE, count words and stalls in BURST.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    grant_d       = grant;
    owner_d       = owner;
    last_owner_d  = last_owner_q;
    word_cnt_d    = word_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    pkt_done_d    = 1'b0;
    err_timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          for (int j = 0; j < NUM_REQ; j++) grant_d[j] = (pick == 2'(j));
          owner_d     = pick;
          word_cnt_d  = '0;
          stall_cnt_d = '0;
          state_d     = BURST;
        end
      end
      BURST: begin
        // An accept always wins over the watchdog threshold.
        if (accept) begin
          stall_cnt_d = '0;
          if (last_word) begin
            pkt_done_d   = 1'b1;
            grant_d      = '0;
            last_owner_d = owner;
            word_cnt_d   = '0;
            state_d      = IDLE;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end else if (stall_limit) begin
          // Abandon the partial packet; downstream sees it truncated.
          err_timeout_d = 1'b1;
          grant_d       = '0;
          last_owner_d  = owner;
          word_cnt_d    = '0;
          stall_cnt_d   = '0;
          state_d       = IDLE;
        end else begin
          stall_cnt_d = stall_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous reset; last_owner starts at the top index
  // so the first scan after reset begins at producer 0.
  always_ff @(posedge clk_400) begin
    // NOTE: non-blocking assignments keep every register update simultaneous.
    if (!rst_n) begin
      state_q      <= IDLE;
      grant        <= '0;
      owner        <= '0;
      last_owner_q <= 2'(NUM_REQ - 1);
      word_cnt_q   <= '0;
      stall_cnt_q  <= '0;
      pkt_done     <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant        <= grant_d;
      owner        <= owner_d;
      last_owner_q <= last_owner_d;
      word_cnt_q   <= word_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      pkt_done     <= pkt_done_d;
      err_timeout  <= err_timeout_d;
    end
  end

endmodule

// File: tb/tb_bus2st_arb.sv
// tb_bus2st_arb: self-checking bench for bus2st_arb. Producers emit tagged
// words; a scoreboard queue holds the words the bus should carry in order.
module tb_bus2st_arb;

  localparam int BUS     = 534;
  localparam int NUM_REQ = 4;
  localparam int NPKT    = 25;
  localparam int TIMEOUT = 1023;

  logic                   clk_400 = 1'b0;
  logic                   rst_n;
  logic [NUM_REQ-1:0]     req;
  logic [NUM_REQ*BUS-1:0] in_data;
  logic [NUM_REQ-1:0]     in_en;
  logic [NUM_REQ-1:0]     in_ready;
  logic [NUM_REQ-1:0]     grant;
  logic [BUS-1:0]         bus_data;
  logic                   bus_en;
  logic                   bus_ready;
  logic [1:0]             owner;
  logic                   pkt_done;
  logic                   err_timeout;

  bus2st_arb #(
    .BUS(BUS), .NUM_REQ(NUM_REQ),
    .NUM_BUS_PER_TURBO_PKT(NPKT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_400(clk_400), .rst_n(rst_n), .req(req), .in_data(in_data),
    .in_en(in_en), .in_ready(in_ready), .grant(grant), .bus_data(bus_data),
    .bus_en(bus_en), .bus_ready(bus_ready), .owner(owner),
    .pkt_done(pkt_done), .err_timeout(err_timeout)
  );

  always #2 clk_400 = ~clk_400;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int n_acc    = 0;
  int n_done   = 0;
  int n_err    = 0;
  int ptr[NUM_REQ];
  logic [BUS-1:0] exp_q[$];

  logic [NUM_REQ-1:0] s_grant, s_in_ready;
  logic [1:0]         s_owner;
  logic               s_done, s_err, s_bus_en, s_accept;
  logic [BUS-1:0]     s_bus_data;

  typedef struct {
    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] in_en;
    logic               rdy;
    logic [NUM_REQ-1:0] exp_grant;
    logic [1:0]         exp_owner;
    logic [NUM_REQ-1:0] exp_in_ready;
    logic               exp_bus_en;
  } vec_t;

  vec_t vecs[6];

  function automatic logic [BUS-1:0] make_word(int p, int k);
    logic [BUS-1:0] w;
    w             = '0;
    w[31:0]       = 32'(p * 1000 + k);
    w[300 +: 8]   = 8'(p + 1);
    w[BUS-1 -: 32] = ~w[31:0];
    return w;
  endfunction

  task automatic check(string name, logic [BUS-1:0] act, logic [BUS-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_words(int p, int first, int n);
    for (int k = first; k < first + n; k++) exp_q.push_back(make_word(p, k));
  endtask

  // One clock cycle: drive producer data, sample at the falling edge, run the
  // scoreboard, then return just after the next rising edge.
  task automatic tick();
    logic [BUS-1:0] e;
    for (int p = 0; p < NUM_REQ; p++) in_data[p*BUS +: BUS] = make_word(p, ptr[p]);
    @(negedge clk_400);
    s_grant    = grant;
    s_in_ready = in_ready;
    s_owner    = owner;
    s_done     = pkt_done;
    s_err      = err_timeout;
    s_bus_en   = bus_en;
    s_bus_data = bus_data;
    s_accept   = bus_en & bus_ready;
    if (s_accept === 1'b1) begin
      n_acc++;
      check("sb_word_expected", BUS'(exp_q.size() != 0), BUS'(1));
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("sb_bus_data", bus_data, e);
      end
    end
    for (int p = 0; p < NUM_REQ; p++) if (in_ready[p] === 1'b1 && in_en[p]) ptr[p]++;
    if (pkt_done === 1'b1) n_done++;
    if (err_timeout === 1'b1) n_err++;
    if (pkt_done === 1'b1 || err_timeout === 1'b1)
      check("done_err_exclusive", BUS'(pkt_done & err_timeout), BUS'(0));
    cyc++;
    @(posedge clk_400);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req       = '0;
    in_en     = '0;
    bus_ready = 1'b0;
    for (int p = 0; p < NUM_REQ; p++) ptr[p] = 0;
    tick();
    tick();
    rst_n = 1'b1;
    exp_q.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int na, last_acc, got, gap_ref, ng, d0, e0, r2_hits;
    int order[5];
    logic [NUM_REQ-1:0] prev_grant;

    for (int p = 0; p < NUM_REQ; p++) ptr[p] = 0;
    in_data = '0;

    // Reset state with every input asserted.
    rst_n = 1'b0; req = '1; in_en = '1; bus_ready = 1'b1;
    tick();
    tick();
    check("rst_grant",    BUS'(s_grant),    BUS'(0));
    check("rst_owner",    BUS'(s_owner),    BUS'(0));
    check("rst_pkt_done", BUS'(s_done),     BUS'(0));
    check("rst_err",      BUS'(s_err),      BUS'(0));
    check("rst_bus_en",   BUS'(s_bus_en),   BUS'(0));
    check("rst_in_ready", BUS'(s_in_ready), BUS'(0));
    check("rst_bus_data", s_bus_data,       BUS'(0));

    // First arbitration after reset (scan starts at producer 0) and
    // combinational gating of non-granted producers.
    vecs[0] = '{4'b0000, 4'b1111, 1'b1, 4'b0000, 2'd0, 4'b0000, 1'b0};
    vecs[1] = '{4'b0001, 4'b0001, 1'b1, 4'b0001, 2'd0, 4'b0001, 1'b1};
    vecs[2] = '{4'b0110, 4'b0100, 1'b1, 4'b0010, 2'd1, 4'b0010, 1'b0};
    vecs[3] = '{4'b1100, 4'b1100, 1'b0, 4'b0100, 2'd2, 4'b0000, 1'b1};
    vecs[4] = '{4'b1000, 4'b0111, 1'b1, 4'b1000, 2'd3, 4'b1000, 1'b0};
    vecs[5] = '{4'b1111, 4'b1111, 1'b1, 4'b0001, 2'd0, 4'b0001, 1'b1};
    for (int v = 0; v < 6; v++) begin
      do_reset();
      req = vecs[v].req; in_en = vecs[v].in_en; bus_ready = vecs[v].rdy;
      tick();
      if (vecs[v].exp_bus_en && vecs[v].rdy) push_words(int'(vecs[v].exp_owner), 0, 1);
      tick();
      check($sformatf("vec%0d_grant", v),    BUS'(s_grant),    BUS'(vecs[v].exp_grant));
      check($sformatf("vec%0d_owner", v),    BUS'(s_owner),    BUS'(vecs[v].exp_owner));
      check($sformatf("vec%0d_in_ready", v), BUS'(s_in_ready), BUS'(vecs[v].exp_in_ready));
      check($sformatf("vec%0d_bus_en", v),   BUS'(s_bus_en),   BUS'(vecs[v].exp_bus_en));
      check($sformatf("vec%0d_bus_data", v), s_bus_data,
            (vecs[v].exp_grant == '0) ? BUS'(0) : make_word(int'(vecs[v].exp_owner), 0));
    end

    // All four producers requesting at full rate: order 0,1,2,3,0, one packet
    // each, pkt_done 27 cycles after the request then every 26 cycles.
    do_reset();
    order = '{0, 1, 2, 3, 0};
    for (int p = 0; p < NUM_REQ; p++) push_words(p, 0, NPKT);
    push_words(0, NPKT, NPKT);
    req = '1; in_en = '1; bus_ready = 1'b1;
    prev_grant = '0; ng = 0; gap_ref = 0; d0 = n_done;
    for (int c = 1; c <= 1 + 5 * 26; c++) begin
      tick();
      if (s_grant != '0 && prev_grant == '0) begin
        if (ng < 5) begin
          check($sformatf("rr_owner%0d", ng), BUS'(s_owner), BUS'(order[ng]));
          check($sformatf("rr_grant%0d", ng), BUS'(s_grant), BUS'(4'b0001 << order[ng]));
        end
        ng++;
      end
      if (s_done) begin
        check("rr_done_spacing", BUS'(c - gap_ref), BUS'((gap_ref == 0) ? 27 : 26));
        check("rr_done_grant_low", BUS'(s_grant), BUS'(0));
        gap_ref = c;
      end
      prev_grant = s_grant;
    end
    check("rr_grants_seen", BUS'(ng), BUS'(5));
    check("rr_done_count", BUS'(n_done - d0), BUS'(5));
    check("rr_sb_drained", BUS'(exp_q.size()), BUS'(0));

    // Owner 1 with bus_ready toggling; producer 2 keeps in_en high meanwhile.
    do_reset();
    req = 4'b0010; in_en = 4'b0110;
    push_words(1, 0, NPKT);
    tick();
    req = 4'b0110;
    na = n_acc; e0 = n_err; got = 0; r2_hits = 0;
    for (int c = 0; c < 100; c++) begin
      bus_ready = (c % 2 == 0);
      tick();
      if (s_in_ready[2] || (s_bus_en && s_grant != 4'b0010)) r2_hits++;
      if (s_done) begin got = 1; break; end
    end
    check("tog_done_seen", BUS'(got), BUS'(1));
    check("tog_accepts", BUS'(n_acc - na), BUS'(NPKT));
    check("tog_no_timeout", BUS'(n_err - e0), BUS'(0));
    check("tog_p2_blocked", BUS'(r2_hits), BUS'(0));
    in_en = '0;
    tick();
    check("tog_next_owner_p2", BUS'(s_grant), BUS'(4'b0100));

    // Owner stalls after 10 words: timeout releases to the next requester.
    do_reset();
    push_words(0, 0, 10);
    req = 4'b0011; in_en = 4'b0001; bus_ready = 1'b1;
    na = 0; last_acc = 0;
    for (int c = 0; c < 40 && na < 10; c++) begin
      tick();
      if (s_accept) begin na++; last_acc = cyc; end
    end
    in_en = '0;
    d0 = n_done; got = 0;
    for (int c = 0; c < TIMEOUT + 20; c++) begin
      tick();
      if (s_err) begin
        got = 1;
        check("to_latency", BUS'(cyc - last_acc), BUS'(TIMEOUT + 1));
        check("to_grant_low", BUS'(s_grant), BUS'(0));
        break;
      end
    end
    check("to_err_seen", BUS'(got), BUS'(1));
    check("to_no_pkt_done", BUS'(n_done - d0), BUS'(0));
    tick();
    check("to_next_owner_p1", BUS'(s_grant), BUS'(4'b0010));
    check("to_err_one_cycle", BUS'(s_err), BUS'(0));

    // Reset in the middle of a burst from producer 2.
    do_reset();
    push_words(2, 0, 12);
    req = 4'b0100; in_en = 4'b0100; bus_ready = 1'b1;
    na = 0;
    for (int c = 0; c < 40 && na < 12; c++) begin
      tick();
      if (s_accept) na++;
    end
    rst_n = 1'b0; req = 4'b0101;
    push_words(2, 12, 1);
    d0 = n_done; e0 = n_err;
    tick();
    check("mrst_word_cnt", BUS'(dut.word_cnt_q), BUS'(0));
    check("mrst_stall_cnt", BUS'(dut.stall_cnt_q), BUS'(0));
    rst_n = 1'b1;
    tick();
    check("mrst_grant", BUS'(s_grant), BUS'(0));
    check("mrst_bus_en", BUS'(s_bus_en), BUS'(0));
    check("mrst_owner", BUS'(s_owner), BUS'(0));
    check("mrst_no_pulses", BUS'((n_done - d0) + (n_err - e0)), BUS'(0));
    tick();
    check("mrst_p0_wins", BUS'(s_grant), BUS'(4'b0001));
    check("mrst_sb_drained", BUS'(exp_q.size()), BUS'(0));

    // Final word accepted on the same cycle the stall counter hits its limit.
    do_reset();
    push_words(0, 0, NPKT);
    req = 4'b0001; in_en = 4'b0001; bus_ready = 1'b1;
    na = 0;
    for (int c = 0; c < 60 && na < NPKT - 1; c++) begin
      tick();
      if (s_accept) na++;
    end
    in_en = '0;
    d0 = n_done; e0 = n_err;
    repeat (TIMEOUT - 1) tick();
    check("edge_stall_at_limit", BUS'(dut.stall_cnt_q), BUS'(TIMEOUT - 1));
    in_en = 4'b0001;
    tick();
    check("edge_final_accept", BUS'(s_accept), BUS'(1));
    in_en = '0;
    tick();
    check("edge_pkt_done", BUS'(s_done), BUS'(1));
    check("edge_no_err", BUS'(s_err), BUS'(0));
    check("edge_grant_low", BUS'(s_grant), BUS'(0));
    tick();
    check("edge_err_total", BUS'(n_err - e0), BUS'(0));
    check("edge_done_total", BUS'(n_done - d0), BUS'(1));
    check("edge_sb_drained", BUS'(exp_q.size()), BUS'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
